bht_write_sched: RTL and testbench

Write scheduler for the FPGA branch history table banks. It owns the single write port of each BHT bank and sequences two kinds of write: a row-by-row clear sweep, after reset and on every flush, and the resolved-branch updates from the execute stage. Updates that arrive during a sweep are held in a small FIFO and released afterwards in order. Updates queued before a flush are discarded. The block sits between the branch-resolution path and the BHT update/clear inputs, inside the frontend.

---
 rtl/bht_write_sched.sv | 134 +++++++++++++
 tb/tb_bht_write_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bht_write_sched.sv
// rtl/bht_write_sched.sv - BHT write-port scheduler: row clear sweeps and buffered branch updates
module bht_write_sched #(
  parameter int NR_ROWS    = 256,
  parameter int PC_W       = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic                       upd_valid_i,
  input  logic [PC_W-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  output logic                       bht_upd_valid_o,
  output logic [PC_W-1:0]            bht_upd_pc_o,
  output logic                       bht_upd_taken_o,
  output logic                       clr_we_o,
  output logic [$clog2(NR_ROWS)-1:0] clr_addr_o,
  output logic                       busy_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int RW = $clog2(NR_ROWS);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [RW-1:0]     r_row, w_row, w_row_nxt;
  logic [AW:0]       r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic [PC_W:0]     r_mem [FIFO_DEPTH];
  logic [DROP_W-1:0] r_drop;
  logic              r_upd_valid, r_upd_taken, r_clr_we, r_busy;
  logic [PC_W-1:0]   r_upd_pc;
  logic [RW-1:0]     r_clr_addr;

  logic          w_empty, w_full, w_empty_nxt, w_sweep_now, w_last_row;
  logic          w_push, w_pop, w_accept, w_drop, w_fifo_wr, w_fifo_rd;
  logic [PC_W:0] w_fwd;
  logic          w_clr_we_nxt, w_upd_valid_nxt, w_busy_nxt;
  logic [RW-1:0] w_clr_addr_nxt;

  // A flush overrides the current state and makes this edge the row-0 clear write.
  assign w_sweep_now = flush_i || (r_state == S_SWEEP);
  assign w_row       = flush_i ? '0 : r_row;
  assign w_last_row  = (w_row == RW'(NR_ROWS - 1));

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = ((r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}});
  assign w_push    = upd_valid_i && !debug_mode_i && !flush_i;
  assign w_pop     = !w_sweep_now && (!w_empty || w_push);
  assign w_accept  = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && !w_accept;
  // An update arriving at an empty FIFO while popping bypasses the storage.
  assign w_fifo_wr = w_accept && !(w_pop && w_empty);
  assign w_fifo_rd = w_pop && !w_empty;
  assign w_fwd     = w_empty ? {upd_taken_i, upd_pc_i} : r_mem[r_rptr[AW-1:0]];

  assign w_wptr_nxt  = flush_i ? r_rptr : (r_wptr + {{AW{1'b0}}, w_fifo_wr});
  assign w_rptr_nxt  = r_rptr + {{AW{1'b0}}, w_fifo_rd};
  assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_SWEEP;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    if (w_sweep_now) begin
      w_row_nxt   = w_row + 1'b1;
      w_state_nxt = S_SWEEP;
      if (w_last_row)
        w_state_nxt = w_empty_nxt ? S_IDLE : S_DRAIN;
    end else if (r_state == S_DRAIN && w_empty_nxt) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_clr_we_nxt    = w_sweep_now;
    w_clr_addr_nxt  = w_sweep_now ? w_row : '0;
    w_upd_valid_nxt = w_pop;
    w_busy_nxt      = flush_i || (r_state != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_drop      <= '0;
      r_upd_valid <= 1'b0;
      r_upd_pc    <= '0;
      r_upd_taken <= 1'b0;
      r_clr_we    <= 1'b0;
      r_clr_addr  <= '0;
      r_busy      <= 1'b1;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_upd_valid <= w_upd_valid_nxt;
      r_clr_we    <= w_clr_we_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_busy      <= w_busy_nxt;
      if (w_pop) begin
        r_upd_pc    <= w_fwd[PC_W-1:0];
        r_upd_taken <= w_fwd[PC_W];
      end
      if (w_drop && !(&r_drop))
        r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fifo_wr)
      r_mem[r_wptr[AW-1:0]] <= {upd_taken_i, upd_pc_i};
  end

  assign bht_upd_valid_o = r_upd_valid;
  assign bht_upd_pc_o    = r_upd_pc;
  assign bht_upd_taken_o = r_upd_taken;
  assign clr_we_o        = r_clr_we;
  assign clr_addr_o      = r_clr_addr;
  assign busy_o          = r_busy;
  assign drop_cnt_o      = r_drop;

endmodule

// File: tb/tb_bht_write_sched.sv
// tb/tb_bht_write_sched.sv - self-checking bench for bht_write_sched
module tb_bht_write_sched;

  localparam int NR    = 256;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, debug = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
  logic [63:0] upd_pc = '0;
  logic        bht_upd_valid, bht_upd_taken, clr_we, busy;
  logic [63:0] bht_upd_pc;
  logic [7:0]  clr_addr, drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending-update queue plus sweep progress counter.
  logic [64:0] m_q[$];
  bit          m_sweeping;
  int          m_row, m_drop;
  logic        e_clr, e_valid, e_taken, e_busy;
  logic [7:0]  e_addr;
  logic [63:0] e_pc;

  bht_write_sched dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(debug),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .bht_upd_valid_o(bht_upd_valid), .bht_upd_pc_o(bht_upd_pc), .bht_upd_taken_o(bht_upd_taken),
    .clr_we_o(clr_we), .clr_addr_o(clr_addr), .busy_o(busy), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_sweeping = 1; m_row = 0; m_drop = 0;
    e_clr = 0; e_addr = 0; e_valid = 0; e_pc = 0; e_taken = 0; e_busy = 1;
  endtask

  task automatic model_step();
    bit push;
    e_busy = m_sweeping || (m_q.size() > 0) || flush;
    push   = upd_valid && !debug && !flush;
    if (flush) begin
      m_q.delete();
      e_clr = 1; e_addr = 0; e_valid = 0;
      m_row = 1; m_sweeping = 1;
    end else if (m_sweeping) begin
      e_clr = 1; e_addr = 8'(m_row); e_valid = 0;
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back({upd_taken, upd_pc});
        else if (m_drop < 255) m_drop++;
      end
      m_row++;
      if (m_row == NR) begin m_sweeping = 0; m_row = 0; end
    end else begin
      e_clr = 0; e_addr = 0;
      if (push) m_q.push_back({upd_taken, upd_pc});
      if (m_q.size() > 0) begin
        {e_taken, e_pc} = m_q.pop_front();
        e_valid = 1;
      end else e_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic wait_addr(input int row, input string name);
    int cnt = 0;
    while (!(clr_we === 1'b1 && clr_addr === 8'(row)) && cnt < 600) begin tick(); cnt++; end
    n_checks++;
    if (cnt >= 600) begin n_fail++; $display("FAIL %s: clr row %0d never seen, last addr %0d", name, row, clr_addr); end
  endtask

  task automatic test_reset();
    rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (clr_we !== 1'b0 || clr_addr !== 8'd0) begin n_fail++; $display("FAIL reset_clr: we=%b addr=%0d expected 0/0", clr_we, clr_addr); end
    n_checks++; if (bht_upd_valid !== 1'b0 || bht_upd_pc !== 64'd0 || bht_upd_taken !== 1'b0) begin n_fail++; $display("FAIL reset_upd: v=%b pc=%h t=%b expected 0", bht_upd_valid, bht_upd_pc, bht_upd_taken); end
    n_checks++; if (busy !== 1'b1 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_busy_drop: busy=%b drop=%0d expected 1/0", busy, drop_cnt); end
    @(negedge clk); rst = 0;
    for (int i = 0; i < NR; i++) begin
      tick();
      n_checks++; if (clr_we !== 1'b1 || clr_addr !== 8'(i)) begin n_fail++; $display("FAIL reset_sweep: we=%b addr=%0d expected 1/%0d", clr_we, clr_addr, i); end
      n_checks++; if (bht_upd_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL reset_sweep_flags: v=%b busy=%b expected 0/1 at row %0d", bht_upd_valid, busy, i); end
    end
    tick();
    n_checks++; if (clr_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_sweep_end: we=%b busy=%b expected 0/0", clr_we, busy); end
  endtask

  task automatic test_idle_updates();
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1; upd_pc = 64'h100 + 64'(4 * i); upd_taken = i[0];
      tick();
      n_checks++;
      if (bht_upd_valid !== 1'b1 || bht_upd_pc !== 64'h100 + 64'(4 * i) || bht_upd_taken !== i[0] || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_fwd %0d: v=%b pc=%h t=%b busy=%b expected 1/%h/%b/0", i, bht_upd_valid, bht_upd_pc, bht_upd_taken, busy, 64'h100 + 64'(4 * i), i[0]);
      end
    end
    upd_valid = 0;
    tick();
    n_checks++; if (bht_upd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_stop: v=%b expected 0", bht_upd_valid); end
  endtask

  task automatic test_sweep_buffer();
    flush = 1; tick(); flush = 0;
    n_checks++; if (clr_we !== 1'b1 || clr_addr !== 8'd0) begin n_fail++; $display("FAIL buf_flush: we=%b addr=%0d expected 1/0", clr_we, clr_addr); end
    for (int i = 0; i < 6; i++) begin
      upd_valid = 1; upd_pc = 64'h200 + 64'(4 * i); upd_taken = ~i[0];
      tick();
      n_checks++; if (bht_upd_valid !== 1'b0 || clr_addr !== 8'(i + 1)) begin n_fail++; $display("FAIL buf_push %0d: v=%b addr=%0d expected 0/%0d", i, bht_upd_valid, clr_addr, i + 1); end
    end
    upd_valid = 0;
    wait_addr(255, "buf_wait");
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bht_upd_valid !== 1'b1 || bht_upd_pc !== 64'h200 + 64'(4 * i) || bht_upd_taken !== ~i[0] || clr_we !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL buf_drain %0d: v=%b pc=%h t=%b we=%b busy=%b expected 1/%h/%b/0/1", i, bht_upd_valid, bht_upd_pc, bht_upd_taken, clr_we, busy, 64'h200 + 64'(4 * i), ~i[0]);
      end
    end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL buf_drop: drop=%0d expected 2", drop_cnt); end
    tick();
    n_checks++; if (bht_upd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL buf_done: v=%b busy=%b expected 0/0", bht_upd_valid, busy); end
  endtask

  task automatic test_flush_discard();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1; upd_pc = 64'h300 + 64'(4 * i); upd_taken = 1; tick();
    end
    upd_valid = 0;
    wait_addr(100, "flush_wait");
    flush = 1; tick(); flush = 0;
    n_checks++; if (clr_we !== 1'b1 || clr_addr !== 8'd0) begin n_fail++; $display("FAIL flush_restart: we=%b addr=%0d expected 1/0", clr_we, clr_addr); end
    for (int i = 1; i < NR; i++) begin
      tick();
      n_checks++; if (clr_we !== 1'b1 || clr_addr !== 8'(i) || bht_upd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_sweep: we=%b addr=%0d v=%b expected 1/%0d/0", clr_we, clr_addr, bht_upd_valid, i); end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bht_upd_valid !== 1'b0 || busy !== 1'b0 || clr_we !== 1'b0) begin n_fail++; $display("FAIL flush_discard: v=%b busy=%b we=%b expected 0/0/0", bht_upd_valid, busy, clr_we); end
    end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL flush_drop: drop=%0d expected 2", drop_cnt); end
  endtask

  task automatic test_ignored();
    upd_valid = 1; debug = 1; upd_pc = 64'h400; tick(); debug = 0; upd_valid = 0;
    n_checks++; if (bht_upd_valid !== 1'b0 || drop_cnt !== 8'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL debug_ignore: v=%b drop=%0d busy=%b expected 0/2/0", bht_upd_valid, drop_cnt, busy); end
    upd_valid = 1; flush = 1; upd_pc = 64'h404; tick(); upd_valid = 0; flush = 0;
    n_checks++; if (bht_upd_valid !== 1'b0 || clr_we !== 1'b1 || clr_addr !== 8'd0) begin n_fail++; $display("FAIL flush_push: v=%b we=%b addr=%0d expected 0/1/0", bht_upd_valid, clr_we, clr_addr); end
    repeat (NR - 1) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bht_upd_valid !== 1'b0 || drop_cnt !== 8'd2) begin n_fail++; $display("FAIL flush_push_after: v=%b drop=%0d expected 0/2", bht_upd_valid, drop_cnt); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      upd_valid = ($urandom_range(99) < 60);
      debug     = ($urandom_range(9) == 0);
      flush     = ($urandom_range(299) == 0);
      upd_pc    = {$urandom, $urandom};
      upd_taken = $urandom_range(1);
      tick();
      n_checks++;
      if (clr_we !== e_clr || clr_addr !== e_addr || bht_upd_valid !== e_valid || busy !== e_busy || drop_cnt !== 8'(m_drop)) begin
        n_fail++; $display("FAIL rand_ctrl c=%0d: we=%b addr=%0d v=%b busy=%b drop=%0d expected %b/%0d/%b/%b/%0d", c, clr_we, clr_addr, bht_upd_valid, busy, drop_cnt, e_clr, e_addr, e_valid, e_busy, m_drop);
      end
      n_checks++;
      if (bht_upd_pc !== e_pc || bht_upd_taken !== e_taken) begin
        n_fail++; $display("FAIL rand_data c=%0d: pc=%h t=%b expected %h/%b", c, bht_upd_pc, bht_upd_taken, e_pc, e_taken);
      end
    end
    upd_valid = 0; debug = 0; flush = 0;
  endtask

  task automatic test_async_reset();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 6; i++) begin
      upd_valid = 1; upd_pc = 64'h500 + 64'(4 * i); upd_taken = 1; tick();
    end
    upd_valid = 0;
    wait_addr(255, "ar_wait");
    tick();
    n_checks++; if (bht_upd_valid !== 1'b1 || busy !== 1'b1 || drop_cnt === 8'd0) begin n_fail++; $display("FAIL ar_drain: v=%b busy=%b drop=%0d expected 1/1/nonzero", bht_upd_valid, busy, drop_cnt); end
    #1 rst = 1;
    #1;
    n_checks++; if (clr_we !== 1'b0 || clr_addr !== 8'd0 || busy !== 1'b1 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ar_ctrl: we=%b addr=%0d busy=%b drop=%0d expected 0/0/1/0", clr_we, clr_addr, busy, drop_cnt); end
    n_checks++; if (bht_upd_valid !== 1'b0 || bht_upd_pc !== 64'd0 || bht_upd_taken !== 1'b0) begin n_fail++; $display("FAIL ar_upd: v=%b pc=%h t=%b expected 0", bht_upd_valid, bht_upd_pc, bht_upd_taken); end
    model_reset();
    @(negedge clk); rst = 0;
    for (int i = 0; i < NR; i++) begin
      tick();
      n_checks++; if (clr_we !== 1'b1 || clr_addr !== 8'(i) || bht_upd_valid !== 1'b0) begin n_fail++; $display("FAIL ar_sweep: we=%b addr=%0d v=%b expected 1/%0d/0", clr_we, clr_addr, bht_upd_valid, i); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bht_upd_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ar_after: v=%b busy=%b drop=%0d expected 0/0/0", bht_upd_valid, busy, drop_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_updates();
    test_sweep_buffer();
    test_flush_discard();
    test_ignored();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
